// File: rtl/threshold_sequencer_pkg.sv
// threshold_sequencer_pkg: state codes and default sizing shared by the sequencer and status logic
package threshold_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEAN_RST = 3'd1,
    ST_MEAN_RUN = 3'd2,
    ST_BIN_RST  = 3'd3,
    ST_BIN_RUN  = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;
  localparam int DEFAULT_CNT_BITS = 20;
  localparam int DEFAULT_RELEASE_DELAY = 2;
endpackage

// File: rtl/threshold_sequencer_run_watchdog.sv
// run_watchdog: saturating run-cycle counter; terminal flags that the count is all-ones after this cycle
module run_watchdog
  import threshold_sequencer_pkg::*;
#(
  parameter int CNT_BITS = DEFAULT_CNT_BITS
) (
  input  logic                clock,
  input  logic                not_reset,
  input  logic                clear,
  input  logic                enable,
  output logic [CNT_BITS-1:0] count,
  output logic                terminal
);
  logic [CNT_BITS-1:0] count_next;
  always_comb begin
    count_next = clear ? '0 : (enable && !(&count)) ? count + 1'b1 : count;
    terminal = &count_next;
  end
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) count <= '0;
    else count <= count_next;
  end
endmodule

// File: rtl/threshold_sequencer.sv
// threshold_sequencer: runs mean then binarize stages, muxes the image read port, watchdogs the run
module threshold_sequencer
  import threshold_sequencer_pkg::*;
#(
  parameter int WIDTH_BITS    = 8,
  parameter int HEIGHT_BITS   = 8,
  parameter int CNT_BITS      = DEFAULT_CNT_BITS,
  parameter int RELEASE_DELAY = DEFAULT_RELEASE_DELAY
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic                   iStart,
  input  logic                   iAbort,
  output logic                   oMeanNotReset,
  input  logic                   iMeanFinished,
  input  logic [WIDTH_BITS-1:0]  iMeanCol,
  input  logic [HEIGHT_BITS-1:0] iMeanRow,
  output logic                   oBinNotReset,
  input  logic                   iBinFinished,
  input  logic [WIDTH_BITS-1:0]  iBinCol,
  input  logic [HEIGHT_BITS-1:0] iBinRow,
  input  logic [WIDTH_BITS-1:0]  iDispCol,
  input  logic [HEIGHT_BITS-1:0] iDispRow,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  output logic                   oDispValid,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oError,
  output logic [2:0]             oStage,
  output logic [CNT_BITS-1:0]    oCycleCount
);
  localparam int HOLD_BITS = $clog2(RELEASE_DELAY + 1);
  localparam logic [HOLD_BITS-1:0] HOLD_INIT = HOLD_BITS'(RELEASE_DELAY - 1);
  state_t state, next_state;
  logic [HOLD_BITS-1:0] hold, next_hold;
  logic mean_sel, bin_sel, run, launch, terminal;
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state <= ST_IDLE;
      hold <= '0;
      oMeanNotReset <= 1'b0;
      oBinNotReset <= 1'b0;
      oDone <= 1'b0;
      oError <= 1'b0;
    end else begin
      state <= next_state;
      hold <= next_hold;
      oMeanNotReset <= next_state == ST_MEAN_RUN;
      oBinNotReset <= next_state == ST_BIN_RUN;
      oDone <= next_state == ST_DONE;
      oError <= next_state == ST_ERROR;
    end
  end
  // abort overrides every other transition, including a start in an idle state
  always_comb begin
    next_state = state;
    next_hold = hold;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        next_state = iStart ? ST_MEAN_RST : state;
        next_hold = iStart ? HOLD_INIT : hold;
      end
      ST_MEAN_RST, ST_BIN_RST: begin
        next_state = hold != '0 ? state : state == ST_MEAN_RST ? ST_MEAN_RUN : ST_BIN_RUN;
        next_hold = hold != '0 ? hold - 1'b1 : hold;
      end
      ST_MEAN_RUN: begin
        next_state = iMeanFinished ? ST_BIN_RST : terminal ? ST_ERROR : state;
        next_hold = HOLD_INIT;
      end
      ST_BIN_RUN: next_state = iBinFinished ? ST_DONE : terminal ? ST_ERROR : state;
      default: next_state = ST_IDLE;
    endcase
    if (iAbort) next_state = ST_IDLE;
  end
  always_comb begin
    mean_sel = state inside {ST_MEAN_RST, ST_MEAN_RUN};
    bin_sel = state inside {ST_BIN_RST, ST_BIN_RUN};
    run = state inside {ST_MEAN_RUN, ST_BIN_RUN};
    oBusy = mean_sel || bin_sel;
    oDispValid = state inside {ST_IDLE, ST_DONE, ST_ERROR};
    launch = oDispValid && iStart && !iAbort;
    oImageCol = mean_sel ? iMeanCol : bin_sel ? iBinCol : iDispCol;
    oImageRow = mean_sel ? iMeanRow : bin_sel ? iBinRow : iDispRow;
    oStage = state;
  end
  run_watchdog #(.CNT_BITS(CNT_BITS)) u_watchdog (
    .clock    (clock),
    .not_reset(not_reset),
    .clear    (launch),
    .enable   (run && !iAbort),
    .count    (oCycleCount),
    .terminal (terminal)
  );
endmodule

// File: tb/tb_threshold_sequencer.sv
// tb_threshold_sequencer: directed scenarios on a wide-counter instance, randomized run against a small-counter instance
module tb_threshold_sequencer;
  localparam int RD = 2;
  localparam int W_MAX = 15;
  logic clock = 1'b0, not_reset = 1'b1;
  logic iStart = 1'b0, iAbort = 1'b0, iMeanFinished = 1'b0, iBinFinished = 1'b0;
  logic [7:0] iMeanCol, iMeanRow, iBinCol, iBinRow, iDispCol, iDispRow;
  logic oMeanNotReset, oBinNotReset, oDispValid, oBusy, oDone, oError;
  logic [7:0] oImageCol, oImageRow;
  logic [2:0] oStage;
  logic [19:0] oCycleCount;
  logic w_mnr, w_bnr, w_disp, w_busy, w_done, w_err;
  logic [7:0] w_col, w_row;
  logic [2:0] w_stage;
  logic [3:0] w_cnt;
  int checks = 0, errors = 0;
  wire [8:0] dut_flags = {oStage, oBusy, oMeanNotReset, oBinNotReset, oDone, oError, oDispValid};
  wire [8:0] w_flags = {w_stage, w_busy, w_mnr, w_bnr, w_done, w_err, w_disp};

  threshold_sequencer #(.CNT_BITS(20), .RELEASE_DELAY(RD)) dut (
    .clock(clock), .not_reset(not_reset), .iStart(iStart), .iAbort(iAbort),
    .oMeanNotReset(oMeanNotReset), .iMeanFinished(iMeanFinished), .iMeanCol(iMeanCol), .iMeanRow(iMeanRow),
    .oBinNotReset(oBinNotReset), .iBinFinished(iBinFinished), .iBinCol(iBinCol), .iBinRow(iBinRow),
    .iDispCol(iDispCol), .iDispRow(iDispRow), .oImageCol(oImageCol), .oImageRow(oImageRow),
    .oDispValid(oDispValid), .oBusy(oBusy), .oDone(oDone), .oError(oError), .oStage(oStage),
    .oCycleCount(oCycleCount));

  threshold_sequencer #(.CNT_BITS(4), .RELEASE_DELAY(RD)) dut_w (
    .clock(clock), .not_reset(not_reset), .iStart(iStart), .iAbort(iAbort),
    .oMeanNotReset(w_mnr), .iMeanFinished(iMeanFinished), .iMeanCol(iMeanCol), .iMeanRow(iMeanRow),
    .oBinNotReset(w_bnr), .iBinFinished(iBinFinished), .iBinCol(iBinCol), .iBinRow(iBinRow),
    .iDispCol(iDispCol), .iDispRow(iDispRow), .oImageCol(w_col), .oImageRow(w_row),
    .oDispValid(w_disp), .oBusy(w_busy), .oDone(w_done), .oError(w_err), .oStage(w_stage),
    .oCycleCount(w_cnt));

  always #5 clock = ~clock;

  // reference for dut_w: stage code, cycles of reset hold remaining, saturating run-cycle total
  typedef struct packed {int st; int rel; int cnt;} model_t;
  model_t m = '0;

  function automatic model_t model_next(model_t c, logic start, logic abort, logic mfin, logic bfin);
    model_t n = c;
    if (abort) n.st = 0;
    else if (c.st == 0 || c.st >= 5) begin
      if (start) begin n.st = 1; n.rel = RD; n.cnt = 0; end
    end else if (c.st == 1 || c.st == 3) begin
      n.rel = c.rel - 1;
      if (n.rel == 0) n.st = c.st + 1;
    end else begin
      n.cnt = c.cnt == W_MAX ? W_MAX : c.cnt + 1;
      if (c.st == 2 ? mfin : bfin) begin n.st = c.st + 1; n.rel = RD; end
      else if (n.cnt == W_MAX) n.st = 6;
    end
    return n;
  endfunction

  always @(posedge clock or negedge not_reset)
    if (!not_reset) m <= '0;
    else m <= model_next(m, iStart, iAbort, iMeanFinished, iBinFinished);

  // status bits implied by a stage code
  function automatic logic [8:0] flags(int st);
    return {3'(st), st >= 1 && st <= 4, st == 2, st == 4, st == 5, st == 6, st == 0 || st >= 5};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic launch();
    iStart = 1'b1;
    step();
    iStart = 1'b0;
  endtask

  task automatic abort_all();
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
  endtask

  task automatic test_reset();
    iMeanCol = 8'h11; iBinCol = 8'h22; iDispCol = 8'h33;
    iMeanRow = 8'h44; iBinRow = 8'h55; iDispRow = 8'h66;
    #2 not_reset = 1'b0;
    #1;
    checks++; if (dut_flags !== flags(0)) begin errors++; $display("FAIL reset_flags: got %b expected %b", dut_flags, flags(0)); end
    checks++; if (oCycleCount !== 20'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", oCycleCount); end
    checks++; if ({oImageCol, oImageRow} !== 16'h3366) begin errors++; $display("FAIL reset_addr: got %h expected 3366", {oImageCol, oImageRow}); end
    checks++; if (w_flags !== flags(0)) begin errors++; $display("FAIL reset_flags_w: got %b expected %b", w_flags, flags(0)); end
    step();
    not_reset = 1'b1;
    step();
    checks++; if (dut_flags !== flags(0)) begin errors++; $display("FAIL reset_release: got %b expected %b", dut_flags, flags(0)); end
  endtask

  task automatic test_normal_run();
    launch();
    checks++; if (dut_flags !== flags(1)) begin errors++; $display("FAIL run_start: got %b expected %b", dut_flags, flags(1)); end
    checks++; if ({oImageCol, oImageRow} !== 16'h1144) begin errors++; $display("FAIL run_mean_addr: got %h expected 1144", {oImageCol, oImageRow}); end
    step();
    checks++; if (dut_flags !== flags(1)) begin errors++; $display("FAIL run_mean_hold: got %b expected %b", dut_flags, flags(1)); end
    step();
    checks++; if (dut_flags !== flags(2)) begin errors++; $display("FAIL run_mean_release: got %b expected %b", dut_flags, flags(2)); end
    repeat (99) step();
    checks++; if (oCycleCount !== 20'd99 || dut_flags !== flags(2)) begin errors++; $display("FAIL run_mean_busy: got %b/%0d expected %b/99", dut_flags, oCycleCount, flags(2)); end
    iMeanFinished = 1'b1;
    step();
    iMeanFinished = 1'b0;
    checks++; if (dut_flags !== flags(3) || oCycleCount !== 20'd100) begin errors++; $display("FAIL run_mean_finish: got %b/%0d expected %b/100", dut_flags, oCycleCount, flags(3)); end
    checks++; if ({oImageCol, oImageRow} !== 16'h2255) begin errors++; $display("FAIL run_bin_addr: got %h expected 2255", {oImageCol, oImageRow}); end
    step();
    step();
    checks++; if (dut_flags !== flags(4)) begin errors++; $display("FAIL run_bin_release: got %b expected %b", dut_flags, flags(4)); end
    repeat (49) step();
    iBinFinished = 1'b1;
    step();
    iBinFinished = 1'b0;
    checks++; if (dut_flags !== flags(5) || oCycleCount !== 20'd150) begin errors++; $display("FAIL run_done: got %b/%0d expected %b/150", dut_flags, oCycleCount, flags(5)); end
    checks++; if ({oImageCol, oImageRow} !== 16'h3366) begin errors++; $display("FAIL run_done_addr: got %h expected 3366", {oImageCol, oImageRow}); end
  endtask

  task automatic test_watchdog();
    launch();
    step();
    step();
    checks++; if (w_flags !== flags(2) || w_cnt !== 4'd0) begin errors++; $display("FAIL wd_enter: got %b/%0d expected %b/0", w_flags, w_cnt, flags(2)); end
    repeat (14) step();
    checks++; if (w_flags !== flags(2) || w_cnt !== 4'd14) begin errors++; $display("FAIL wd_before: got %b/%0d expected %b/14", w_flags, w_cnt, flags(2)); end
    step();
    checks++; if (w_flags !== flags(6) || w_cnt !== 4'd15) begin errors++; $display("FAIL wd_timeout: got %b/%0d expected %b/15", w_flags, w_cnt, flags(6)); end
    launch();
    checks++; if (w_flags !== flags(1) || w_cnt !== 4'd0) begin errors++; $display("FAIL wd_restart: got %b/%0d expected %b/0", w_flags, w_cnt, flags(1)); end
    abort_all();
  endtask

  task automatic test_finish_vs_timeout();
    launch();
    repeat (16) step();
    iMeanFinished = 1'b1;
    step();
    iMeanFinished = 1'b0;
    checks++; if (w_flags !== flags(3) || w_cnt !== 4'd15) begin errors++; $display("FAIL finish_beats_timeout: got %b/%0d expected %b/15", w_flags, w_cnt, flags(3)); end
    abort_all();
  endtask

  task automatic test_abort();
    launch();
    step();
    step();
    iMeanFinished = 1'b1;
    step();
    iMeanFinished = 1'b0;
    repeat (7) step();
    checks++; if (dut_flags !== flags(4) || oCycleCount !== 20'd6) begin errors++; $display("FAIL abort_pre: got %b/%0d expected %b/6", dut_flags, oCycleCount, flags(4)); end
    iAbort = 1'b1;
    step();
    checks++; if (dut_flags !== flags(0) || oCycleCount !== 20'd6) begin errors++; $display("FAIL abort_bin_run: got %b/%0d expected %b/6", dut_flags, oCycleCount, flags(0)); end
    iStart = 1'b1;
    step();
    {iStart, iAbort} = 2'b00;
    checks++; if (dut_flags !== flags(0) || oCycleCount !== 20'd6) begin errors++; $display("FAIL abort_beats_start: got %b/%0d expected %b/6", dut_flags, oCycleCount, flags(0)); end
  endtask

  task automatic test_ignored();
    launch();
    step();
    step();
    {iStart, iBinFinished} = 2'b11;
    repeat (5) step();
    {iStart, iBinFinished} = 2'b00;
    checks++; if (dut_flags !== flags(2) || oCycleCount !== 20'd5) begin errors++; $display("FAIL ignored_inputs: got %b/%0d expected %b/5", dut_flags, oCycleCount, flags(2)); end
    abort_all();
  endtask

  task automatic test_async_reset();
    launch();
    step();
    step();
    iMeanFinished = 1'b1;
    step();
    iMeanFinished = 1'b0;
    repeat (3) step();
    checks++; if (dut_flags !== flags(4)) begin errors++; $display("FAIL async_pre: got %b expected %b", dut_flags, flags(4)); end
    #3 not_reset = 1'b0;
    #1;
    checks++; if (dut_flags !== flags(0) || oCycleCount !== 20'd0) begin errors++; $display("FAIL async_reset: got %b/%0d expected %b/0", dut_flags, oCycleCount, flags(0)); end
    checks++; if ({oImageCol, oImageRow} !== 16'h3366) begin errors++; $display("FAIL async_addr: got %h expected 3366", {oImageCol, oImageRow}); end
    #2 not_reset = 1'b1;
    step();
    checks++; if (dut_flags !== flags(0)) begin errors++; $display("FAIL async_release: got %b expected %b", dut_flags, flags(0)); end
  endtask

  task automatic test_random();
    logic [15:0] exp_addr;
    for (int i = 0; i < 1500; i++) begin
      iStart = $urandom_range(0, 9) < 3;
      iAbort = $urandom_range(0, 19) == 0;
      iMeanFinished = $urandom_range(0, 4) == 0;
      iBinFinished = $urandom_range(0, 4) == 0;
      {iMeanCol, iMeanRow, iBinCol, iBinRow} = $urandom;
      {iDispCol, iDispRow} = 16'($urandom);
      #1;
      exp_addr = (m.st == 1 || m.st == 2) ? {iMeanCol, iMeanRow} : (m.st == 3 || m.st == 4) ? {iBinCol, iBinRow} : {iDispCol, iDispRow};
      checks++; if (w_flags !== flags(m.st) || w_cnt !== m.cnt[3:0]) begin errors++; $display("FAIL random_state cycle %0d: got %b/%0d expected %b/%0d", i, w_flags, w_cnt, flags(m.st), m.cnt); end
      checks++; if ({w_col, w_row} !== exp_addr) begin errors++; $display("FAIL random_addr cycle %0d: got %h expected %h", i, {w_col, w_row}, exp_addr); end
      step();
    end
    {iStart, iAbort, iMeanFinished, iBinFinished} = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_watchdog();
    test_finish_vs_timeout();
    test_abort();
    test_ignored();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
